mem_bus_bridge: RTL and testbench

//  Avalon-MM style slave sitting between the MIPS CPU data/instruction bus master and the

---
 rtl/mem_bus_bridge.sv | 129 ++++++++++++
 tb/tb_mem_bus_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// Avalon-MM style slave bridging the CPU waitrequest handshake onto a simple
// registered-read RAM port, with optional fixed/pseudo-random wait states.
module mem_bus_bridge #(
  parameter int          WAIT_CYCLES = 0,
  parameter int          RANDOM_WAIT = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [31:0] ram_a,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  output logic [3:0]  ram_byteenable,
  input  logic [31:0] ram_rd
);

  localparam logic [7:0] LP_WAIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [15:0] r_lfsr;
  logic [31:0] r_ram_a;
  logic [31:0] r_ram_wd;
  logic [3:0]  r_ram_be;
  logic [31:0] r_hold;
  logic        r_op_rd;
  logic        r_op_wr;
  logic        r_err;

  logic        w_req;
  logic        w_illegal;
  logic [7:0]  w_extra;

  assign w_req     = read | write;
  assign w_illegal = (read & write) | (address[1:0] != 2'b00);
  assign w_extra   = LP_WAIT + ((RANDOM_WAIT != 0) ? {6'b0, r_lfsr[1:0]} : 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_illegal)          w_next = S_DONE;
          else if (w_extra != '0) w_next = S_WAIT;
          else                    w_next = S_ISSUE;
        end
      end
      S_WAIT:  if (r_cnt == 8'd1) w_next = S_ISSUE;
      S_ISSUE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_lfsr   <= LFSR_SEED;
      r_ram_a  <= '0;
      r_ram_wd <= '0;
      r_ram_be <= '0;
      r_hold   <= '0;
      r_op_rd  <= 1'b0;
      r_op_wr  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (RANDOM_WAIT != 0) begin
        r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_ram_a  <= address;
            r_ram_wd <= writedata;
            r_ram_be <= byteenable;
            r_op_rd  <= read;
            r_op_wr  <= write;
            r_err    <= w_illegal;
            r_cnt    <= w_extra;
          end
        end
        S_WAIT: r_cnt <= r_cnt - 8'd1;
        S_DONE: if (r_op_rd && !r_err) r_hold <= ram_rd;
        default: ;
      endcase
    end
  end

  // Completion outputs decode from state so reset forces them low immediately.
  assign waitrequest    = w_req & (r_state != S_DONE);
  assign ram_we         = (r_state == S_ISSUE) & r_op_wr & ~r_err;
  assign err            = (r_state == S_DONE) & r_err;
  assign ram_a          = r_ram_a;
  assign ram_wd         = r_ram_wd;
  assign ram_byteenable = r_ram_be;

  always_comb begin
    readdata = r_hold;
    if (r_state == S_DONE) begin
      if (r_err)        readdata = '0;
      else if (r_op_rd) readdata = ram_rd;
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: four instances (no wait, 3 waits, 4 waits,
// random waits), each with its own byte-array RAM model.
module tb_mem_bus_bridge;

  logic        clk;
  logic        rst_n   [4];
  logic [31:0] addr    [4];
  logic        rd      [4];
  logic        wr      [4];
  logic [31:0] wdata   [4];
  logic [3:0]  be      [4];
  logic        wreq    [4];
  logic [31:0] rdata   [4];
  logic        err     [4];
  logic [31:0] ram_a   [4];
  logic        ram_we  [4];
  logic [31:0] ram_wd  [4];
  logic [3:0]  ram_be  [4];
  logic [31:0] ram_rd  [4];

  logic [7:0]  mem     [4][256];
  int          we_cnt  [4];
  logic [31:0] model   [64];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WC = (g == 1) ? 3 : ((g == 2) ? 4 : 0);
    localparam int RW = (g == 3) ? 1 : 0;
    mem_bus_bridge #(
      .WAIT_CYCLES(WC),
      .RANDOM_WAIT(RW),
      .LFSR_SEED  (16'hACE1)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .address       (addr[g]),
      .read          (rd[g]),
      .write         (wr[g]),
      .writedata     (wdata[g]),
      .byteenable    (be[g]),
      .waitrequest   (wreq[g]),
      .readdata      (rdata[g]),
      .err           (err[g]),
      .ram_a         (ram_a[g]),
      .ram_we        (ram_we[g]),
      .ram_wd        (ram_wd[g]),
      .ram_byteenable(ram_be[g]),
      .ram_rd        (ram_rd[g])
    );
  end

  // Big-endian byte RAM: byteenable[3] is the byte at the word address.
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      logic [7:0] ai;
      ai = ram_a[g][7:0];
      if (ram_we[g] === 1'b1) begin
        we_cnt[g] = we_cnt[g] + 1;
        if (ram_be[g][3]) mem[g][ai]          <= ram_wd[g][31:24];
        if (ram_be[g][2]) mem[g][8'(ai + 1)]  <= ram_wd[g][23:16];
        if (ram_be[g][1]) mem[g][8'(ai + 2)]  <= ram_wd[g][15:8];
        if (ram_be[g][0]) mem[g][8'(ai + 3)]  <= ram_wd[g][7:0];
      end
      ram_rd[g] <= {mem[g][ai], mem[g][8'(ai + 1)], mem[g][8'(ai + 2)], mem[g][8'(ai + 3)]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Runs one transfer starting at posedge+1; returns at posedge+1 after completion.
  task automatic do_op(input int g, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rdv, output logic errv,
                       output int wes, output logic [31:0] cap_a, output logic [31:0] cap_wd,
                       output logic [3:0] cap_be, output logic [7:0] wseq);
    int  we0;
    bit  done;
    we0    = we_cnt[g];
    rd[g]  = r;
    wr[g]  = w;
    addr[g] = a;
    wdata[g] = d;
    be[g]  = b;
    lat    = 0;
    done   = 0;
    wseq   = '0;
    rdv    = '0;
    errv   = 1'b0;
    cap_a  = '0;
    cap_wd = '0;
    cap_be = '0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat  = lat + 1;
      wseq = {wseq[6:0], wreq[g]};
      if (ram_we[g]) begin
        cap_a  = ram_a[g];
        cap_wd = ram_wd[g];
        cap_be = ram_be[g];
      end
      if (!wreq[g]) begin
        done = 1;
        rdv  = rdata[g];
        errv = err[g];
      end
    end
    if (!done) chk("op_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    rd[g] = 1'b0;
    wr[g] = 1'b0;
    wes   = we_cnt[g] - we0;
  endtask

  initial begin
    int          lat;
    int          wes;
    int          we_base;
    logic [31:0] rdv;
    logic        errv;
    logic [31:0] ca;
    logic [31:0] cwd;
    logic [3:0]  cbe;
    logic [7:0]  wseq;

    for (int g = 0; g < 4; g++) begin
      rst_n[g] = 1'b0;
      rd[g] = 1'b0;
      wr[g] = 1'b0;
      addr[g] = '0;
      wdata[g] = '0;
      be[g] = '0;
      we_cnt[g] = 0;
      for (int i = 0; i < 256; i++) mem[g][i] = 8'h00;
    end
    for (int i = 0; i < 64; i++) model[i] = '0;
    mem[0][0] = 8'h11; mem[0][1] = 8'h22; mem[0][2] = 8'h33; mem[0][3] = 8'h44;
    mem[1][4] = 8'h55; mem[1][5] = 8'h66; mem[1][6] = 8'h77; mem[1][7] = 8'h88;
    mem[2][8] = 8'h99; mem[2][9] = 8'hAA; mem[2][10] = 8'hBB; mem[2][11] = 8'hCC;

    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, ram_we[0]}, 32'd0);
    chk("rst_err", {31'd0, err[0]}, 32'd0);
    chk("rst_ram_a", ram_a[0], 32'd0);
    chk("rst_readdata", rdata[0], 32'd0);
    @(posedge clk); #1;
    for (int g = 0; g < 4; g++) rst_n[g] = 1'b1;
    @(posedge clk); #1;

    // Plain read, no waits
    do_op(0, 1, 0, 32'hBFC00000, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("rd_wseq", {24'd0, wseq}, 32'b110);
    chk("rd_data", rdv, 32'h11223344);
    chk("rd_err", {31'd0, errv}, 32'd0);
    chk("rd_no_we", wes, 0);

    // Full write then read back
    do_op(0, 0, 1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("wr_wseq", {24'd0, wseq}, 32'b110);
    chk("wr_we_once", wes, 1);
    chk("wr_ram_a", ca, 32'hBFC00010);
    chk("wr_ram_wd", cwd, 32'hDEADBEEF);
    chk("wr_ram_be", {28'd0, cbe}, 32'hF);
    do_op(0, 1, 0, 32'hBFC00010, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("wr_readback", rdv, 32'hDEADBEEF);

    // Partial byte lanes, then a zero-lane write that must still be issued
    do_op(0, 0, 1, 32'hBFC00010, 32'h01020304, 4'b0101, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("pwr_we_once", wes, 1);
    do_op(0, 1, 0, 32'hBFC00010, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("pwr_readback", rdv, 32'hDE02BE04);
    do_op(0, 0, 1, 32'hBFC00010, 32'hFFFFFFFF, 4'h0, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("be0_we_once", wes, 1);
    chk("be0_lat", lat, 3);
    do_op(0, 1, 0, 32'hBFC00010, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("be0_readback", rdv, 32'hDE02BE04);

    // Fixed wait states
    do_op(1, 1, 0, 32'hBFC00004, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("w3_wseq", {24'd0, wseq}, 32'b111110);
    chk("w3_data", rdv, 32'h55667788);

    // Illegal: read&write, then misaligned read
    do_op(0, 1, 1, 32'hBFC00000, 32'h12345678, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("ill_rw_wseq", {24'd0, wseq}, 32'b10);
    chk("ill_rw_err", {31'd0, errv}, 32'd1);
    chk("ill_rw_data", rdv, 32'd0);
    chk("ill_rw_no_we", wes, 0);
    do_op(0, 1, 0, 32'hBFC00002, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("ill_mis_wseq", {24'd0, wseq}, 32'b10);
    chk("ill_mis_err", {31'd0, errv}, 32'd1);
    chk("ill_mis_data", rdv, 32'd0);
    chk("ill_mis_no_we", wes, 0);
    @(negedge clk);
    chk("held_after_ill", rdata[0], 32'hDE02BE04);
    chk("idle_err", {31'd0, err[0]}, 32'd0);
    @(posedge clk); #1;

    // Reset during WAIT aborts the write; held read restarts after release
    we_base = we_cnt[2];
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'hBFC0000C; wdata[2] = 32'hCAFEF00D; be[2] = 4'hF;
    repeat (3) @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("abort_we", {31'd0, ram_we[2]}, 32'd0);
    chk("abort_err", {31'd0, err[2]}, 32'd0);
    chk("abort_ram_a", ram_a[2], 32'd0);
    wr[2] = 1'b0; rd[2] = 1'b1; addr[2] = 32'hBFC00008;
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    do_op(2, 1, 0, 32'hBFC00008, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("restart_lat", lat, 7);
    chk("restart_data", rdv, 32'h99AABBCC);
    do_op(2, 1, 0, 32'hBFC0000C, 32'h0, 4'hF, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
    chk("aborted_target", rdv, 32'd0);
    chk("abort_no_we", we_cnt[2] - we_base, 0);

    // Random wait states with a scoreboard
    for (int i = 0; i < 1000; i++) begin
      int          kind;
      int          k;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic        r;
      logic        w;
      kind = int'($urandom_range(0, 5));
      k    = int'($urandom_range(0, 63));
      a    = 32'hBFC00000 + 32'(k << 2);
      d    = $urandom;
      b    = 4'($urandom_range(0, 15));
      r    = (kind <= 1) || (kind >= 4);
      w    = (kind == 2) || (kind == 3) || (kind == 4);
      if (kind == 5) a = a | 32'($urandom_range(1, 3));
      do_op(3, r, w, a, d, b, lat, rdv, errv, wes, ca, cwd, cbe, wseq);
      if (kind >= 4) begin
        chk("rnd_ill_lat", lat, 2);
        chk("rnd_ill_err", {31'd0, errv}, 32'd1);
        chk("rnd_ill_data", rdv, 32'd0);
        chk("rnd_ill_we", wes, 0);
      end else begin
        chk("rnd_lat_range", {31'd0, (lat >= 3 && lat <= 6)}, 32'd1);
        chk("rnd_err", {31'd0, errv}, 32'd0);
        chk("rnd_we", wes, w ? 1 : 0);
        if (r) chk("rnd_rdata", rdv, model[k]);
        if (w) begin
          if (b[3]) model[k][31:24] = d[31:24];
          if (b[2]) model[k][23:16] = d[23:16];
          if (b[1]) model[k][15:8]  = d[15:8];
          if (b[0]) model[k][7:0]   = d[7:0];
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
